// File: rtl/ysyx_22041461_mul_iter_if.sv
// Request/response bundle for the iterative multiplier: operands and opcode in,
// one 64-bit product out, plus pipeline flush.
interface ysyx_22041461_mul_iter_if #(
  parameter int XLEN = 64
);
  // Handshake: a request transfers on a rising edge where in_valid && in_ready;
  // a result transfers on a rising edge where out_valid && out_ready. Once
  // asserted, out_valid and MUL_out hold until that transfer or a flush/reset.
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic [4:0]      ctrl_ALU;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] MUL_out;
  logic [1:0]      dbg_state;

  modport master (
    output in_valid, src1, src2, ctrl_ALU, flush, out_ready,
    input  in_ready, out_valid, MUL_out, dbg_state
  );

  modport slave (
    input  in_valid, src1, src2, ctrl_ALU, flush, out_ready,
    output in_ready, out_valid, MUL_out, dbg_state
  );
endinterface

// File: rtl/ysyx_22041461_mul_iter.sv
// Iterative shift-add multiplier for RV64M MUL/MULH/MULHSU/MULHU/MULW:
// operands are reduced to magnitudes, one multiplier bit per cycle, sign fixed at the end.
module ysyx_22041461_mul_iter #(
  parameter int XLEN      = 64,
  parameter bit ZERO_SKIP = 1'b1
) (
  input logic                      clk,
  input logic                      rst_n,
  ysyx_22041461_mul_iter_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_e;
  typedef enum logic [2:0] {
    OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2,
    OP_MULHU = 3'd3, OP_MULW = 3'd4, OP_BAD = 3'd5
  } op_e;

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [2*XLEN-1:0] mcand_q, mcand_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [XLEN-1:0]   out_q, out_d;
  logic [5:0]        cnt_q, cnt_d;
  logic              sign_q, sign_d;

  // Request decode: signedness per opcode, then magnitudes.
  op_e             op_dec;
  logic            neg_a, neg_b;
  logic [XLEN-1:0] a_w, b_w, mag_a, mag_b;

  always_comb begin
    op_dec = OP_BAD;
    neg_a  = 1'b0;
    neg_b  = 1'b0;
    a_w    = bus.src1;
    b_w    = bus.src2;
    case (bus.ctrl_ALU)
      5'b01110: op_dec = OP_MUL;
      5'b01111: begin
        op_dec = OP_MULH;
        neg_a  = bus.src1[XLEN-1];
        neg_b  = bus.src2[XLEN-1];
      end
      5'b10000: begin
        op_dec = OP_MULHSU;
        neg_a  = bus.src1[XLEN-1];
      end
      5'b10001: op_dec = OP_MULHU;
      5'b10010: begin
        op_dec = OP_MULW;
        a_w    = {{(XLEN-32){1'b0}}, bus.src1[31:0]};
        b_w    = {{(XLEN-32){1'b0}}, bus.src2[31:0]};
      end
      default: op_dec = OP_BAD;
    endcase
    // -(2^63) stays representable as an unsigned 64-bit magnitude.
    mag_a = neg_a ? (~a_w + 1'b1) : a_w;
    mag_b = neg_b ? (~b_w + 1'b1) : b_w;
  end

  logic [2*XLEN-1:0] acc_sum, acc_fin;
  logic [XLEN-1:0]   result;
  logic              last_iter, skip;

  always_comb begin
    acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
    acc_fin   = sign_q ? (~acc_sum + 1'b1) : acc_sum;
    last_iter = (op_q == OP_MULW) ? (cnt_q == 6'd31) : (cnt_q == 6'd63);
    // Zero check is only meaningful before any shifting has happened.
    skip      = (cnt_q == 6'd0) &&
                ((op_q == OP_BAD) ||
                 (ZERO_SKIP && ((mcand_q == '0) || (mplier_q == '0))));
    case (op_q)
      OP_MUL:  result = acc_fin[XLEN-1:0];
      OP_MULW: result = {{(XLEN-32){acc_fin[31]}}, acc_fin[31:0]};
      default: result = acc_fin[2*XLEN-1:XLEN];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    out_d    = out_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    case (state_q)
      S_IDLE: begin
        if (!bus.flush && bus.in_valid) begin
          state_d  = S_CALC;
          op_d     = op_dec;
          mcand_d  = {{XLEN{1'b0}}, mag_a};
          mplier_d = mag_b;
          acc_d    = '0;
          cnt_d    = 6'd0;
          sign_d   = neg_a ^ neg_b;
        end
      end
      S_CALC: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else if (skip) begin
          state_d = S_DONE;
          out_d   = '0;
        end else begin
          acc_d    = acc_sum;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 6'd1;
          if (last_iter) begin
            state_d = S_DONE;
            out_d   = result;
          end
        end
      end
      S_DONE: begin
        if (bus.flush || bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MUL;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      out_q    <= '0;
      cnt_q    <= 6'd0;
      sign_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      out_q    <= out_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.MUL_out   = out_q;
  assign bus.dbg_state = state_q;
endmodule
